// File: rtl/if_fetch.sv
// if_fetch: IF stage; assembles 32-bit instructions from four byte reads
// and feeds IF_ID. The optional direct-mapped icache is enabled by ICACHE_EN.
// Ports: clk, rst (sync, active-high), rdy (global enable), stall[4:0],
//   use_npc/npc_addr (ID redirect), mem_req/mem_addr/mem_gnt/mem_rdata
//   (byte memory port), if_pc/if_inst (to IF_ID), stall_req (no inst ready).
module if_fetch #(
  parameter logic [16:0] RESET_PC     = 17'h0,
  parameter int          ICACHE_IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [4:0]  stall,
  input  logic        use_npc,
  input  logic [16:0] npc_addr,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_rdata,
  output logic        mem_req,
  output logic [16:0] mem_addr,
  output logic [16:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stall_req
);

  typedef enum logic [2:0] {
    S_IDLE, S_B0, S_B1, S_B2, S_B3, S_DONE
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [16:0] pc;
  logic [16:0] pc_n;
  logic [31:0] inst_r;
  logic        gnt_q;
  logic        redir;
  logic        fire;
  logic        fill;
  logic        req_n;
  logic [16:0] addr_n;
  logic        hit_cur;
  logic        hit_nxt;
  logic [31:0] line_cur;

  logic unused_stall;
  assign unused_stall = ^{stall[4:2], stall[0]};

  assign redir     = rdy & use_npc & ~stall[1];
  assign fire      = mem_req & mem_gnt;
  assign stall_req = (state != S_DONE);
  // A redirect turns the slot into a bubble in the same cycle so IF_ID
  // never latches a wrong-path instruction.
  assign if_inst   = (state == S_DONE && !redir) ? inst_r : 32'h0;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    fill    = 1'b0;
    if (redir) begin
      state_n = S_IDLE;
      pc_n    = npc_addr;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (hit_cur)   state_n = S_DONE;
          else if (fire) state_n = S_B0;
        end
        S_B0: if (fire) state_n = S_B1;
        S_B1: if (fire) state_n = S_B2;
        S_B2: if (fire) state_n = S_B3;
        S_B3: begin
          if (gnt_q) begin
            state_n = S_DONE;
            fill    = 1'b1;
          end
        end
        S_DONE: begin
          if (!stall[1]) begin
            state_n = S_IDLE;
            pc_n    = pc + 17'd4;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Request outputs are registered from the next state; an icache hit
  // on the next pc suppresses the memory request.
  always_comb begin
    req_n  = 1'b0;
    addr_n = mem_addr;
    unique case (state_n)
      S_IDLE: begin
        req_n  = ~hit_nxt;
        addr_n = pc_n;
      end
      S_B0: begin
        req_n  = 1'b1;
        addr_n = pc_n + 17'd1;
      end
      S_B1: begin
        req_n  = 1'b1;
        addr_n = pc_n + 17'd2;
      end
      S_B2: begin
        req_n  = 1'b1;
        addr_n = pc_n + 17'd3;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= 17'h0;
      inst_r   <= 32'h0;
      if_pc    <= 17'h0;
      gnt_q    <= 1'b0;
    end else if (rdy) begin
      state    <= state_n;
      pc       <= pc_n;
      mem_req  <= req_n;
      mem_addr <= addr_n;
      // Byte is valid only in the cycle after its grant.
      gnt_q    <= fire & ~redir;
      if (gnt_q && !redir) begin
        unique case (state)
          S_B0:    inst_r[7:0]   <= mem_rdata;
          S_B1:    inst_r[15:8]  <= mem_rdata;
          S_B2:    inst_r[23:16] <= mem_rdata;
          S_B3:    inst_r[31:24] <= mem_rdata;
          default: ;
        endcase
      end
      if (state == S_IDLE && hit_cur && !redir) inst_r <= line_cur;
      if (state_n == S_DONE && state != S_DONE) if_pc <= pc;
    end
  end

`ifdef ICACHE_EN
  localparam int LINES = 1 << ICACHE_IDX_W;
  localparam int TAG_W = 15 - ICACHE_IDX_W;

  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tags [LINES];
  logic [31:0]             data [LINES];
  logic [ICACHE_IDX_W-1:0] idx_cur;
  logic [ICACHE_IDX_W-1:0] idx_nxt;

  assign idx_cur  = pc[ICACHE_IDX_W+1:2];
  assign idx_nxt  = pc_n[ICACHE_IDX_W+1:2];
  assign hit_cur  = valid[idx_cur] &&
                    tags[idx_cur] == pc[16:ICACHE_IDX_W+2];
  assign hit_nxt  = valid[idx_nxt] &&
                    tags[idx_nxt] == pc_n[16:ICACHE_IDX_W+2];
  assign line_cur = data[idx_cur];

  // fill is never set on a redirect, so aborted fetches leave lines alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (rdy && fill) begin
      valid[idx_cur] <= 1'b1;
      tags[idx_cur]  <= pc[16:ICACHE_IDX_W+2];
      data[idx_cur]  <= {mem_rdata, inst_r[23:0]};
    end
  end
`else
  logic unused_nocache;
  assign hit_cur        = 1'b0;
  assign hit_nxt        = 1'b0;
  assign line_cur       = 32'h0;
  assign unused_nocache = fill | (ICACHE_IDX_W == 0);
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed + randomized bench for if_fetch with a byte
// memory controller model and a pc/instruction stream reference model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [4:0]  stall;
  logic        use_npc;
  logic [16:0] npc_addr;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;
  logic        mem_req;
  logic [16:0] mem_addr;
  logic [16:0] if_pc;
  logic [31:0] if_inst;
  logic        stall_req;

  logic [7:0] mem [0:131071];
  int checks;
  int errors;

  if_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .stall     (stall),
    .use_npc   (use_npc),
    .npc_addr  (npc_addr),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [16:0] a);
    return {mem[a + 17'd3], mem[a + 17'd2], mem[a + 17'd1], mem[a]};
  endfunction

  // One clock; the controller returns the granted byte in the next
  // cycle, junk otherwise, and freezes with rdy.
  task automatic tick();
    logic        g;
    logic        r;
    logic [16:0] a;
    g = mem_req && mem_gnt && rdy && !rst;
    r = rdy;
    a = mem_addr;
    @(posedge clk);
    #1;
    if (r) mem_rdata = g ? mem[a] : 8'($urandom);
  endtask

  task automatic wait_done(input int lim, input string nm);
    int n;
    n = 0;
    while (stall_req && n < lim) begin
      tick();
      n++;
    end
    checks++;
    if (stall_req !== 1'b0) begin
      errors++;
      $display("FAIL %s timeout stall_req=%0b want 0", nm, stall_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; stall = 5'b0; use_npc = 1'b0;
    npc_addr = 17'h0; mem_gnt = 1'b1; mem_rdata = 8'h0;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 17'h0) begin
      errors++;
      $display("FAIL reset_mem req=%0b addr=%h want 0/0", mem_req, mem_addr);
    end
    checks++;
    if (if_inst !== 32'h0 || if_pc !== 17'h0 || stall_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_out inst=%h pc=%h sr=%0b want 0/0/1",
               if_inst, if_pc, stall_req);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    stall[1] = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 17'(k)) begin
        errors++;
        $display("FAIL basic_addr%0d req=%0b addr=%h want 1/%h",
                 k, mem_req, mem_addr, 17'(k));
      end
      tick();
    end
    checks++;
    if (mem_req !== 1'b0 || stall_req !== 1'b1) begin
      errors++;
      $display("FAIL basic_b3 req=%0b sr=%0b want 0/1", mem_req, stall_req);
    end
    tick();
    checks++;
    if (if_inst !== 32'h00100513 || if_pc !== 17'h0 || stall_req !== 1'b0) begin
      errors++;
      $display("FAIL basic_done inst=%h pc=%h sr=%0b want 00100513/0/0",
               if_inst, if_pc, stall_req);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (if_inst !== 32'h00100513 || if_pc !== 17'h0 ||
          mem_req !== 1'b0 || stall_req !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d inst=%h pc=%h req=%0b sr=%0b", i,
                 if_inst, if_pc, mem_req, stall_req);
      end
    end
    stall[1] = 1'b0;
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 17'h4 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL hold_release req=%0b addr=%h inst=%h want 1/4/0",
               mem_req, mem_addr, if_inst);
    end
  endtask

  task automatic test_wait_states();
    stall[1] = 1'b1;
    mem_gnt = 1'b1;
    tick();
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 17'h6) begin
        errors++;
        $display("FAIL wait_hold%0d req=%0b addr=%h want 1/6",
                 i, mem_req, mem_addr);
      end
    end
    mem_gnt = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (stall_req !== 1'b0 || if_inst !== word(17'h4) || if_pc !== 17'h4) begin
      errors++;
      $display("FAIL wait_done sr=%0b inst=%h pc=%h want 0/%h/4",
               stall_req, if_inst, if_pc, word(17'h4));
    end
  endtask

  task automatic test_redirect();
    stall[1] = 1'b0;
    tick();
    tick();
    tick();
    use_npc = 1'b1;
    npc_addr = 17'h100;
    #1;
    checks++;
    if (if_inst !== 32'h0) begin
      errors++;
      $display("FAIL redir_bubble inst=%h want 0", if_inst);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 17'h100) begin
      errors++;
      $display("FAIL redir_addr req=%0b addr=%h want 1/100", mem_req, mem_addr);
    end
    use_npc = 1'b0;
    stall[1] = 1'b1;
    wait_done(20, "redir_wait");
    checks++;
    if (if_inst !== word(17'h100) || if_pc !== 17'h100) begin
      errors++;
      $display("FAIL redir_inst inst=%h pc=%h want %h/100",
               if_inst, if_pc, word(17'h100));
    end
  endtask

  task automatic test_redirect_stalled();
    use_npc = 1'b1;
    npc_addr = 17'h2A4;
    #1;
    checks++;
    if (if_inst !== word(17'h100)) begin
      errors++;
      $display("FAIL stalled_redir_inst inst=%h want %h",
               if_inst, word(17'h100));
    end
    tick();
    tick();
    tick();
    checks++;
    if (if_pc !== 17'h100 || stall_req !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL stalled_redir_hold pc=%h sr=%0b req=%0b want 100/0/0",
               if_pc, stall_req, mem_req);
    end
    stall[1] = 1'b0;
    #1;
    checks++;
    if (if_inst !== 32'h0) begin
      errors++;
      $display("FAIL done_redir_bubble inst=%h want 0", if_inst);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 17'h2A4) begin
      errors++;
      $display("FAIL stalled_redir_addr req=%0b addr=%h want 1/2a4",
               mem_req, mem_addr);
    end
    use_npc = 1'b0;
    stall[1] = 1'b1;
    wait_done(20, "stalled_redir_wait");
    checks++;
    if (if_inst !== word(17'h2A4) || if_pc !== 17'h2A4) begin
      errors++;
      $display("FAIL stalled_redir_done inst=%h pc=%h want %h/2a4",
               if_inst, if_pc, word(17'h2A4));
    end
  endtask

  task automatic test_refetch();
    stall[1] = 1'b0;
    use_npc = 1'b1;
    npc_addr = 17'h2A4;
    tick();
    use_npc = 1'b0;
    stall[1] = 1'b1;
`ifdef ICACHE_EN
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL icache_noreq req=%0b want 0", mem_req);
    end
    tick();
    checks++;
    if (stall_req !== 1'b0 || if_inst !== word(17'h2A4) || if_pc !== 17'h2A4) begin
      errors++;
      $display("FAIL icache_hit sr=%0b inst=%h pc=%h want 0/%h/2a4",
               stall_req, if_inst, if_pc, word(17'h2A4));
    end
`else
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 17'h2A4) begin
      errors++;
      $display("FAIL refetch_req req=%0b addr=%h want 1/2a4", mem_req, mem_addr);
    end
    wait_done(20, "refetch_wait");
    checks++;
    if (if_inst !== word(17'h2A4) || if_pc !== 17'h2A4) begin
      errors++;
      $display("FAIL refetch_done inst=%h pc=%h want %h/2a4",
               if_inst, if_pc, word(17'h2A4));
    end
`endif
  endtask

  task automatic test_midreset();
    stall[1] = 1'b0;
    tick();
    stall[1] = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || stall_req !== 1'b1 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL midreset req=%0b sr=%0b inst=%h want 0/1/0",
               mem_req, stall_req, if_inst);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 17'h0) begin
      errors++;
      $display("FAIL midreset_first req=%0b addr=%h want 1/0",
               mem_req, mem_addr);
    end
  endtask

  // Reference: the IF_ID stream is word(pc) for pc advancing by 4 on each
  // consume, replaced by the target on each accepted redirect.
  task automatic test_random();
    logic [16:0] exp_pc;
    logic [16:0] tgt;
    logic        pend;
    logic        taken;
    int          consumed;
    exp_pc = 17'h0;
    tgt = 17'h0;
    pend = 1'b0;
    consumed = 0;
    for (int c = 0; c < 4000; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      mem_gnt = ($urandom_range(0, 3) != 0);
      stall[1] = ($urandom_range(0, 2) == 0);
      if (!pend && $urandom_range(0, 24) == 0) begin
        pend = 1'b1;
        tgt = 17'($urandom_range(0, 63)) << 2;
      end
      use_npc = pend;
      npc_addr = tgt;
      #1;
      taken = rdy && pend && !stall[1];
      if (stall_req === 1'b0) begin
        checks++;
        if (taken) begin
          if (if_inst !== 32'h0) begin
            errors++;
            $display("FAIL rnd_bubble c=%0d inst=%h want 0", c, if_inst);
          end
        end else if (if_pc !== exp_pc || if_inst !== word(exp_pc)) begin
          errors++;
          $display("FAIL rnd_inst c=%0d pc=%h inst=%h want %h/%h",
                   c, if_pc, if_inst, exp_pc, word(exp_pc));
        end
      end
      if (mem_req && mem_gnt && rdy) begin
        checks++;
        if (17'(mem_addr - exp_pc) > 17'd3) begin
          errors++;
          $display("FAIL rnd_addr c=%0d addr=%h pc=%h", c, mem_addr, exp_pc);
        end
      end
      if (taken) begin
        exp_pc = tgt;
        pend = 1'b0;
      end else if (rdy && stall_req === 1'b0 && !stall[1]) begin
        exp_pc = exp_pc + 17'd4;
        consumed++;
      end
      tick();
    end
    checks++;
    if (consumed < 50) begin
      errors++;
      $display("FAIL rnd_progress consumed=%0d want >=50", consumed);
    end
    rdy = 1'b1;
    use_npc = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 131072; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13;
    mem[1] = 8'h05;
    mem[2] = 8'h10;
    mem[3] = 8'h00;
    test_reset();
    test_basic();
    test_hold();
    test_wait_states();
    test_redirect();
    test_redirect_stalled();
    test_refetch();
    test_midreset();
    test_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
